// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Signed or unsigned operation is selected per transaction. One Booth step
// runs per clock, and the result is held until the consumer takes it.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        operand handshake (in_ready high only in IDLE)
//   multiplier, multiplicand   Q and M operands, sampled only at accept
//   signed_mode                1 = two's complement, 0 = unsigned
//   out_valid / out_ready      result handshake
//   prod                       2*WIDTH-bit product, held until the next completion
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH+1:0]   a_q, a_d;       // accumulator, two guard bits so -M and 2^W-1 fit
    logic [WIDTH+1:0]   m_q, m_d;
    logic [WIDTH:0]     q_q, q_d;       // one extra bit lets unsigned Q read as a positive signed value
    logic               qm1_q, qm1_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [WIDTH+1:0]   a_sum, a_sh;
    logic [WIDTH:0]     q_sh;

    // One Booth step: add/subtract M, then arithmetic shift of {A,Q,q_-1}.
    always_comb begin
        a_sum = a_q;
        case ({q_q[0], qm1_q})
            2'b01:   a_sum = a_q + m_q;
            2'b10:   a_sum = a_q - m_q;
            default: a_sum = a_q;
        endcase
        a_sh = {a_sum[WIDTH+1], a_sum[WIDTH+1:1]};
        q_sh = {a_sum[0], q_q[WIDTH:1]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    m_d     = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                                          : {2'b00, multiplicand};
                    q_d     = signed_mode ? {multiplier[WIDTH-1], multiplier}
                                          : {1'b0, multiplier};
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                a_d   = a_sh;
                q_d   = q_sh;
                qm1_d = q_q[0];
                cnt_d = cnt_q + CW'(1);
                // Last of WIDTH+1 steps: the low 2*WIDTH bits of {A,Q} are exact.
                if (cnt_q == CW'(WIDTH)) begin
                    prod_d  = {a_sh[WIDTH-2:0], q_sh};
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign prod      = prod_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: scoreboard bench for booth_mult_seq.
// An 8-bit instance runs directed vectors (latency, DONE hold, reset abort,
// back-to-back); a 4-bit instance runs an exhaustive sweep in both modes.
// Expected products are queued at accept and popped by per-instance monitors.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic        in_valid = 1'b0, in_ready, smode = 1'b0, out_valid, out_ready = 1'b1;
    logic [7:0]  mpr = '0, mcd = '0;
    logic [15:0] prod;

    // 4-bit instance
    logic        in_valid4 = 1'b0, in_ready4, smode4 = 1'b0, out_valid4, out_ready4 = 1'b1;
    logic [3:0]  mpr4 = '0, mcd4 = '0;
    logic [7:0]  prod4;

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .multiplier(mpr), .multiplicand(mcd), .signed_mode(smode),
        .out_valid(out_valid), .out_ready(out_ready), .prod(prod)
    );

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .multiplier(mpr4), .multiplicand(mcd4), .signed_mode(smode4),
        .out_valid(out_valid4), .out_ready(out_ready4), .prod(prod4)
    );

    int n_tot = 0, n_pass = 0;
    int cyc = 0;
    logic [15:0] exp8[$];
    logic [7:0]  exp4[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Monitors: a result is consumed on the edge following a valid&&ready sample.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp8.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_out8: got %0h with empty scoreboard", prod);
            end else begin
                chk("prod8", 32'(prod), 32'(exp8.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid4 && out_ready4) begin
            if (exp4.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_out4: got %0h with empty scoreboard", prod4);
            end else begin
                chk("prod4", 32'(prod4), 32'(exp4.pop_front()));
            end
        end
    end

    // Called just after a clock edge; returns just after the accept edge.
    task automatic issue8(input logic [7:0] q, input logic [7:0] m, input logic s,
                          input logic [15:0] e, input bit push);
        int t = 0;
        mpr = q; mcd = m; smode = s; in_valid = 1'b1;
        while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
        if (!in_ready) begin
            chk("accept_timeout8", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (push) exp8.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic issue4(input logic [3:0] q, input logic [3:0] m, input logic s,
                          input logic [7:0] e);
        int t = 0;
        mpr4 = q; mcd4 = m; smode4 = s; in_valid4 = 1'b1;
        while (!in_ready4 && t < 100) begin @(posedge clk); #1; t++; end
        if (!in_ready4) begin
            chk("accept_timeout4", 32'(in_ready4), 32'd1);
            in_valid4 = 1'b0;
            return;
        end
        exp4.push_back(e);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp8.size() != 0 || exp4.size() != 0) && t < 200) begin @(posedge clk); #1; t++; end
        chk("drain8", 32'(exp8.size()), 32'd0);
        chk("drain4", 32'(exp4.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, prev, t_acc, t, x, y;
        logic [3:0] a4, b4;
        logic [7:0] bv_q [4], bv_m [4];
        logic       bv_s [4];
        logic [15:0] bv_e [4];

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_prod", 32'(prod), 32'd0);
        chk("rst_prod4", 32'(prod4), 32'd0);

        // Unsigned 0xFF*0xFF: latency, then DONE hold with in_valid pulsed
        out_ready = 1'b0;
        issue8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("latency", 32'(n), 32'd9);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin mpr = 8'h03; mcd = 8'h05; smode = 1'b0; in_valid = 1'b1; end
            if (i == 4) in_valid = 1'b0;
            chk("done_in_ready", 32'(in_ready), 32'd0);
            chk("done_prod_hold", 32'(prod), 32'hFE01);
            chk("done_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_out_valid", 32'(out_valid), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
        chk("post_hs_prod", 32'(prod), 32'hFE01);
        repeat (12) @(posedge clk);
        #1 chk("no_ghost_op", 32'(out_valid), 32'd0);

        // Signed corner cases
        issue8(8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
        issue8(8'h80, 8'h7F, 1'b1, 16'hC080, 1'b1);
        issue8(8'hFF, 8'h01, 1'b1, 16'hFFFF, 1'b1);
        drain();

        // Reset mid-BUSY aborts with no output
        issue8(8'h12, 8'h34, 1'b0, 16'h0000, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_prod", 32'(prod), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid2", 32'(out_valid), 32'd0);
        chk("abort_prod2", 32'(prod), 32'd0);
        issue8(8'h03, 8'h05, 1'b0, 16'h000F, 1'b1);
        drain();

        // Back-to-back, in_valid and out_ready high, mode toggled mid-BUSY
        bv_q[0] = 8'h80; bv_m[0] = 8'h80; bv_s[0] = 1'b1; bv_e[0] = 16'h4000;
        bv_q[1] = 8'hFF; bv_m[1] = 8'h02; bv_s[1] = 1'b0; bv_e[1] = 16'h01FE;
        bv_q[2] = 8'hFF; bv_m[2] = 8'h02; bv_s[2] = 1'b1; bv_e[2] = 16'hFFFE;
        bv_q[3] = 8'h80; bv_m[3] = 8'h7F; bv_s[3] = 1'b0; bv_e[3] = 16'h3F80;
        out_ready = 1'b1;
        in_valid = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            mpr = bv_q[i]; mcd = bv_m[i]; smode = bv_s[i];
            t = 0;
            while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
            if (!in_ready) chk("b2b_accept_timeout", 32'(in_ready), 32'd1);
            exp8.push_back(bv_e[i]);
            @(posedge clk); #1;
            t_acc = cyc;
            if (i > 0) chk("b2b_interval", 32'(t_acc - prev), 32'd11);
            prev = t_acc;
            repeat (3) begin @(posedge clk); #1; end
            smode = ~smode; mpr = 8'hA5; mcd = 8'h5A;
            repeat (3) begin @(posedge clk); #1; end
        end
        in_valid = 1'b0;
        drain();

        // WIDTH=4 exhaustive sweep against a reference multiply
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    a4 = 4'(a); b4 = 4'(b);
                    x = (s == 1) ? int'($signed(a4)) : int'(a4);
                    y = (s == 1) ? int'($signed(b4)) : int'(b4);
                    issue4(a4, b4, s[0], 8'(x * y));
                end
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
